// File: rtl/arria5_dmtd_pll_ctrl.sv
// -----------------------------------------------------------------------------
// arria5_dmtd_pll_ctrl
//
// Lock supervisor for the Arria V DMTD PLL. Runs on the free-running 20 MHz
// reference clock that feeds the PLL, drives the PLL reset and qualifies the
// asynchronous PLL lock indication. The downstream DMTD logic only sees
// `ready` after the PLL has held lock for STABLE_CYCLES. On lock timeout or
// lock loss the PLL is re-reset automatically. Saturating event counters are
// kept for diagnostics.
//
// Parameters
//   RST_CYCLES    PLL reset pulse length in refclk cycles (>=1)
//   LOCK_TIMEOUT  cycles allowed waiting for lock before re-reset (>=1)
//   STABLE_CYCLES continuous synchronized-lock cycles required before ready
//   CNT_W         width of the diagnostic counters
//
// Ports
//   refclk       in   reference clock, the only clock
//   rst          in   asynchronous active-high reset
//   relock       in   refclk-domain pulse forcing a PLL reset sequence
//   pll_locked   in   PLL locked, asynchronous to refclk
//   pll_rst      out  PLL reset, registered
//   ready        out  DMTD clock qualified, registered
//   state        out  FSM state: RST=0, WAIT=1, STAB=2, LOCKED=3
//   loss_cnt     out  lock-loss events (LOCKED->RST), saturating
//   timeout_cnt  out  lock-timeout events (WAIT->RST), saturating
// -----------------------------------------------------------------------------
module arria5_dmtd_pll_ctrl #(
    parameter int RST_CYCLES    = 20,
    parameter int LOCK_TIMEOUT  = 20000,
    parameter int STABLE_CYCLES = 2000,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             relock,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    // Shared cycle counter is sized for the longest of the three intervals.
    localparam int MAX_T_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_T   = (MAX_T_A > STABLE_CYCLES) ? MAX_T_A : STABLE_CYCLES;
    localparam int CW      = (MAX_T > 1) ? $clog2(MAX_T + 1) : 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STAB   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Lock synchronizer: pll_locked is fully asynchronous to refclk.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   locked_s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge refclk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= pll_locked;
                end
            end else begin : g_rest
                always_ff @(posedge refclk or posedge rst) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign locked_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Next-state / next-counter logic
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [CNT_W-1:0] loss_cnt_reg, loss_cnt_next;
    logic [CNT_W-1:0] timeout_cnt_reg, timeout_cnt_next;
    logic             pll_rst_reg, ready_reg;
    logic             loss_event, timeout_event;

    always_comb begin
        state_next    = state_reg;
        loss_event    = 1'b0;
        timeout_event = 1'b0;

        if (relock) begin
            // relock overrides every other event and is never counted
            state_next = ST_RST;
        end else begin
            case (state_reg)
                ST_RST: begin
                    if (cnt_reg == RST_LAST) state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    // a lock arriving on the timeout cycle wins
                    if (locked_s) begin
                        state_next = ST_STAB;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next    = ST_RST;
                        timeout_event = 1'b1;
                    end
                end
                ST_STAB: begin
                    if (!locked_s)                  state_next = ST_WAIT;
                    else if (cnt_reg == STABLE_LAST) state_next = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (!locked_s) begin
                        state_next = ST_RST;
                        loss_event = 1'b1;
                    end
                end
                default: state_next = ST_RST;
            endcase
        end
    end

    always_comb begin
        // relock also restarts the pulse when already in RST
        if (relock || (state_next != state_reg)) begin
            cnt_next = '0;
        end else if (cnt_reg != {CW{1'b1}}) begin
            cnt_next = cnt_reg + 1'b1;
        end else begin
            // parked at all-ones while LOCKED; never wraps
            cnt_next = cnt_reg;
        end
    end

    always_comb begin
        loss_cnt_next    = loss_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;
        if (loss_event && (loss_cnt_reg != {CNT_W{1'b1}}))
            loss_cnt_next = loss_cnt_reg + 1'b1;
        if (timeout_event && (timeout_cnt_reg != {CNT_W{1'b1}}))
            timeout_cnt_next = timeout_cnt_reg + 1'b1;
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_RST;
            cnt_reg         <= '0;
            pll_rst_reg     <= 1'b1;
            ready_reg       <= 1'b0;
            loss_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            // outputs follow the next state so they change on the same edge
            pll_rst_reg     <= (state_next == ST_RST);
            ready_reg       <= (state_next == ST_LOCKED);
            loss_cnt_reg    <= loss_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
        end
    end

    assign pll_rst     = pll_rst_reg;
    assign ready       = ready_reg;
    assign state       = state_reg;
    assign loss_cnt    = loss_cnt_reg;
    assign timeout_cnt = timeout_cnt_reg;

endmodule
